// File: rtl/systolic_pe_mac_if.sv
// rtl/systolic_pe_mac_if.sv - operand, control and result bundle of one systolic MAC processing element
interface systolic_pe_mac_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
   parameter int K_WIDTH    = 8
);
   logic [DATA_WIDTH-1:0] up_i;
   logic                  up_vld_i;
   logic [DATA_WIDTH-1:0] left_i;
   logic                  left_vld_i;
   logic                  start_i;
   logic [K_WIDTH-1:0]    k_len_i;
   logic [DATA_WIDTH-1:0] down_o;
   logic                  down_vld_o;
   logic [DATA_WIDTH-1:0] right_o;
   logic                  right_vld_o;
   logic [ACC_WIDTH-1:0]  res_o;
   logic                  res_vld_o;
   logic                  busy_o;
   logic                  ovf_o;

   modport master (
      output up_i, up_vld_i, left_i, left_vld_i, start_i, k_len_i,
      input  down_o, down_vld_o, right_o, right_vld_o, res_o, res_vld_o, busy_o, ovf_o
   );

   modport slave (
      input  up_i, up_vld_i, left_i, left_vld_i, start_i, k_len_i,
      output down_o, down_vld_o, right_o, right_vld_o, res_o, res_vld_o, busy_o, ovf_o
   );
endinterface

// File: rtl/systolic_pe_mac.sv
// rtl/systolic_pe_mac.sv - systolic PE: valid-qualified MAC over K products with registered operand forwarding
// Define PE_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module systolic_pe_mac #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
   parameter int K_WIDTH    = 8,
   parameter bit SIGNED     = 1'b0,
   parameter bit PIPE_MUL   = 1'b0
) (
   input logic              clk_i,
   input logic              rst_ni,
   systolic_pe_mac_if.slave pe
);
   localparam int PW  = 2*DATA_WIDTH;
   localparam int MSB = ACC_WIDTH-1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [K_WIDTH-1:0]    k_q, k_d, cnt_q, cnt_d, cnt_inc;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d, res_q, res_d;
   logic                  res_vld_q, res_vld_d, ovf_q, ovf_d;
   logic                  start_ok;

   logic [DATA_WIDTH-1:0] down_q, right_q;
   logic                  down_vld_q, right_vld_q;

   logic                  prod_en;
   logic [PW-1:0]         op_a, op_b, prod_raw;
   logic [ACC_WIDTH-1:0]  prod_ext;
   logic [ACC_WIDTH-1:0]  add_val;
   logic                  add_en;

   logic [ACC_WIDTH:0]    sum_full;
   logic [ACC_WIDTH-1:0]  sum_wrap, acc_step;
   logic                  add_ovf;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         down_q      <= '0;
         down_vld_q  <= 1'b0;
         right_q     <= '0;
         right_vld_q <= 1'b0;
      end else begin
         down_q      <= pe.up_i;
         down_vld_q  <= pe.up_vld_i;
         right_q     <= pe.left_i;
         right_vld_q <= pe.left_vld_i;
      end
   end

   // Operands are widened to the product width so one multiplier serves both signed and unsigned modes.
   always_comb begin
      prod_en = pe.up_vld_i & pe.left_vld_i;
      if (SIGNED) begin
         op_a = {{DATA_WIDTH{pe.up_i[DATA_WIDTH-1]}}, pe.up_i};
         op_b = {{DATA_WIDTH{pe.left_i[DATA_WIDTH-1]}}, pe.left_i};
      end else begin
         op_a = {{DATA_WIDTH{1'b0}}, pe.up_i};
         op_b = {{DATA_WIDTH{1'b0}}, pe.left_i};
      end
      prod_raw         = op_a * op_b;
      prod_ext         = {ACC_WIDTH{SIGNED & prod_raw[PW-1]}};
      prod_ext[PW-1:0] = prod_raw;
   end

   generate
      if (PIPE_MUL) begin : g_pipe
         logic [ACC_WIDTH-1:0] prod_q;
         logic                 en_q;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               prod_q <= '0;
               en_q   <= 1'b0;
            end else begin
               prod_q <= prod_ext;
               en_q   <= prod_en;
            end
         end

         assign add_val = prod_q;
         assign add_en  = en_q;
      end else begin : g_comb
         assign add_val = prod_ext;
         assign add_en  = prod_en;
      end
   endgenerate

   always_comb begin
      sum_full = {1'b0, acc_q} + {1'b0, add_val};
      sum_wrap = sum_full[ACC_WIDTH-1:0];
      if (SIGNED) begin
         add_ovf = (acc_q[MSB] == add_val[MSB]) && (sum_wrap[MSB] != acc_q[MSB]);
      end else begin
         add_ovf = sum_full[ACC_WIDTH];
      end
`ifdef PE_SATURATE_EN
      if (!add_ovf) begin
         acc_step = sum_wrap;
      end else if (!SIGNED) begin
         acc_step = '1;
      end else if (acc_q[MSB]) begin
         acc_step = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
         acc_step = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
`else
      acc_step = sum_wrap;
`endif
   end

   // A start with k_len_i==0 is ignored in every state, so a running dot product is never aborted into a dead run.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      res_d     = res_q;
      res_vld_d = 1'b0;
      ovf_d     = ovf_q;
      cnt_inc   = cnt_q + K_WIDTH'(1);
      start_ok  = pe.start_i && (pe.k_len_i != '0);

      if (start_ok) begin
         k_d     = pe.k_len_i;
         cnt_d   = '0;
         acc_d   = '0;
         ovf_d   = 1'b0;
         state_d = S_ACC;
         if (!PIPE_MUL && prod_en) begin
            acc_d = prod_ext;
            cnt_d = K_WIDTH'(1);
            if (pe.k_len_i == K_WIDTH'(1)) begin
               res_d     = prod_ext;
               res_vld_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
      end else begin
         case (state_q)
            S_ACC: begin
               if (add_en) begin
                  acc_d = acc_step;
                  cnt_d = cnt_inc;
                  ovf_d = ovf_q | add_ovf;
                  if (cnt_inc == k_q) begin
                     res_d     = acc_step;
                     res_vld_d = 1'b1;
                     state_d   = PIPE_MUL ? S_FLUSH : S_IDLE;
                  end
               end
            end
            S_FLUSH: state_d = S_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         ovf_q     <= ovf_d;
      end
   end

   assign pe.down_o      = down_q;
   assign pe.down_vld_o  = down_vld_q;
   assign pe.right_o     = right_q;
   assign pe.right_vld_o = right_vld_q;
   assign pe.res_o       = res_q;
   assign pe.res_vld_o   = res_vld_q;
   assign pe.busy_o      = (state_q != S_IDLE);
   assign pe.ovf_o       = ovf_q;
endmodule

// File: tb/tb_systolic_pe_mac.sv
// tb/tb_systolic_pe_mac.sv - scoreboard bench: unsigned combinational-multiply PE and signed pipelined PE
module tb_systolic_pe_mac;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   logic echo_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   systolic_pe_mac_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_WIDTH(8)) bus_u ();
   systolic_pe_mac_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_WIDTH(8)) bus_s ();

   systolic_pe_mac #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_WIDTH(8), .SIGNED(1'b0), .PIPE_MUL(1'b0)) dut_u (
      .clk_i(clk), .rst_ni(rst_n), .pe(bus_u)
   );
   systolic_pe_mac #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_WIDTH(8), .SIGNED(1'b1), .PIPE_MUL(1'b1)) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .pe(bus_s)
   );

   typedef struct packed {
      logic [15:0] res;
      logic        ovf;
      logic [31:0] cyc;
   } exp_t;

   exp_t q_u[$];
   exp_t q_s[$];
   exp_t e_u, e_s;
   logic [7:0] up_prev, left_prev;
   logic       up_vld_prev, left_vld_prev;

`ifdef PE_SATURATE_EN
   localparam logic [15:0] U_OVF_RES = 16'hFFFF;
   localparam logic [15:0] S_OVF_RES = 16'h7FFF;
`else
   localparam logic [15:0] U_OVF_RES = 16'hFC02;
   localparam logic [15:0] S_OVF_RES = 16'h8000;
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_u(input logic st, input logic [7:0] k, input logic vu, input logic [7:0] a,
                          input logic vl, input logic [7:0] b);
      @(posedge clk);
      #1;
      bus_u.start_i = st; bus_u.k_len_i = k;
      bus_u.up_vld_i = vu; bus_u.up_i = a;
      bus_u.left_vld_i = vl; bus_u.left_i = b;
   endtask

   task automatic drive_s(input logic st, input logic [7:0] k, input logic vu, input logic [7:0] a,
                          input logic vl, input logic [7:0] b);
      @(posedge clk);
      #1;
      bus_s.start_i = st; bus_s.k_len_i = k;
      bus_s.up_vld_i = vu; bus_s.up_i = a;
      bus_s.left_vld_i = vl; bus_s.left_i = b;
   endtask

   task automatic push_u(input logic [15:0] r, input logic o, input int lat);
      exp_t e;
      e.res = r; e.ovf = o; e.cyc = 32'(cyc + lat);
      q_u.push_back(e);
   endtask

   task automatic push_s(input logic [15:0] r, input logic o, input int lat);
      exp_t e;
      e.res = r; e.ovf = o; e.cyc = 32'(cyc + lat);
      q_s.push_back(e);
   endtask

   always @(posedge clk) begin
      up_prev       <= bus_u.up_i;
      left_prev     <= bus_u.left_i;
      up_vld_prev   <= bus_u.up_vld_i;
      left_vld_prev <= bus_u.left_vld_i;
   end

   always @(negedge clk) begin
      if (echo_en) begin
         check("u_down", bus_u.down_o, up_prev);
         check("u_down_vld", bus_u.down_vld_o, up_vld_prev);
         check("u_right", bus_u.right_o, left_prev);
         check("u_right_vld", bus_u.right_vld_o, left_vld_prev);
      end
      if (rst_n && bus_u.res_vld_o) begin
         if (q_u.size() == 0) begin
            check("u_unexpected_res_vld", 1'b1, 1'b0);
         end else begin
            e_u = q_u.pop_front();
            check("u_res", bus_u.res_o, e_u.res);
            check("u_ovf", bus_u.ovf_o, e_u.ovf);
            check("u_latency", 32'(cyc), e_u.cyc);
         end
      end
      if (rst_n && bus_s.res_vld_o) begin
         if (q_s.size() == 0) begin
            check("s_unexpected_res_vld", 1'b1, 1'b0);
         end else begin
            e_s = q_s.pop_front();
            check("s_res", bus_s.res_o, e_s.res);
            check("s_ovf", bus_s.ovf_o, e_s.ovf);
            check("s_latency", 32'(cyc), e_s.cyc);
         end
      end
   end

   initial begin
      bus_u.start_i = 1'b0; bus_u.k_len_i = '0; bus_u.up_i = '0; bus_u.up_vld_i = 1'b0;
      bus_u.left_i = '0; bus_u.left_vld_i = 1'b0;
      bus_s.start_i = 1'b0; bus_s.k_len_i = '0; bus_s.up_i = '0; bus_s.up_vld_i = 1'b0;
      bus_s.left_i = '0; bus_s.left_vld_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_u_res", bus_u.res_o, 16'h0);
      check("rst_u_res_vld", bus_u.res_vld_o, 1'b0);
      check("rst_u_busy", bus_u.busy_o, 1'b0);
      check("rst_u_ovf", bus_u.ovf_o, 1'b0);
      check("rst_u_down_vld", bus_u.down_vld_o, 1'b0);
      check("rst_s_res", bus_s.res_o, 16'h0);
      check("rst_s_busy", bus_s.busy_o, 1'b0);

      // K=3, first pair on the start cycle, forwarding echoed one cycle late
      echo_en = 1'b1;
      drive_u(1, 3, 1, 2, 1, 3);
      drive_u(0, 0, 1, 4, 1, 5);
      check("u_busy_in_acc", bus_u.busy_o, 1'b1);
      drive_u(0, 0, 1, 6, 1, 7);
      push_u(16'd68, 1'b0, 1);
      drive_u(0, 0, 0, 8'hA5, 0, 8'h5A);
      drive_u(0, 0, 1, 8'h11, 0, 8'h22);
      drive_u(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      echo_en = 1'b0;
      check("u_idle_after_result", bus_u.busy_o, 1'b0);

      // Abort after two products, restart with K=1; a single-sided valid must not count
      drive_u(1, 4, 1, 1, 1, 1);
      drive_u(0, 0, 1, 2, 1, 2);
      drive_u(1, 1, 0, 0, 0, 0);
      drive_u(0, 0, 1, 7, 0, 7);
      drive_u(0, 0, 1, 9, 1, 9);
      push_u(16'd81, 1'b0, 1);
      drive_u(0, 0, 0, 0, 0, 0);
      drive_u(0, 0, 0, 0, 0, 0);

      // Unsigned overflow, sticky flag, zero-length start ignored, next start clears it
      drive_u(1, 2, 1, 255, 1, 255);
      drive_u(0, 0, 1, 255, 1, 255);
      push_u(U_OVF_RES, 1'b1, 1);
      drive_u(0, 0, 0, 0, 0, 0);
      drive_u(1, 0, 1, 1, 1, 1);
      drive_u(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("u_ovf_sticky", bus_u.ovf_o, 1'b1);
      check("u_k0_start_ignored", bus_u.busy_o, 1'b0);
      drive_u(1, 1, 1, 1, 1, 1);
      push_u(16'd1, 1'b0, 1);

      // Result pulse coincides with the next accepted start
      drive_u(1, 1, 1, 3, 1, 3);
      push_u(16'd9, 1'b0, 1);
      drive_u(1, 1, 1, 4, 1, 4);
      push_u(16'd16, 1'b0, 1);
      drive_u(0, 0, 0, 0, 0, 0);
      drive_u(0, 0, 0, 0, 0, 0);

      // Signed, pipelined: stale pipe product discarded at start, gap not counted
      drive_s(0, 0, 1, 7, 1, 7);
      drive_s(1, 2, 1, 8'(-3), 1, 4);
      drive_s(0, 0, 0, 0, 0, 0);
      drive_s(0, 0, 1, 5, 1, 8'(-6));
      push_s(16'hFFD6, 1'b0, 2);
      repeat (3) drive_s(0, 0, 0, 0, 0, 0);
      drive_s(1, 1, 1, 8'(-128), 1, 8'(-128));
      push_s(16'h4000, 1'b0, 2);
      repeat (3) drive_s(0, 0, 0, 0, 0, 0);
      drive_s(1, 2, 1, 8'(-128), 1, 8'(-128));
      drive_s(0, 0, 1, 8'(-128), 1, 8'(-128));
      push_s(S_OVF_RES, 1'b1, 2);
      repeat (4) drive_s(0, 0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a K=4 run after two products
      drive_u(1, 4, 1, 2, 1, 2);
      drive_u(0, 0, 1, 3, 1, 3);
      drive_u(0, 0, 0, 8'h55, 0, 8'h66);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_u_busy", bus_u.busy_o, 1'b0);
      check("arst_u_res", bus_u.res_o, 16'h0);
      check("arst_u_down", bus_u.down_o, 8'h0);
      check("arst_u_right", bus_u.right_o, 8'h0);
      check("arst_u_ovf", bus_u.ovf_o, 1'b0);
      check("arst_s_res", bus_s.res_o, 16'h0);
      check("arst_s_ovf", bus_s.ovf_o, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive_u(0, 0, 1, 4, 1, 4);
      drive_u(0, 0, 1, 4, 1, 4);
      repeat (4) drive_u(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("u_idle_after_reset", bus_u.busy_o, 1'b0);

      repeat (3) @(negedge clk);
      check("u_scoreboard_drained", q_u.size(), 0);
      check("s_scoreboard_drained", q_s.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
